orpsoc_rst_seq: RTL and testbench
=================================

# orpsoc_rst_seq

Parametrised, synthesisable reset sequencer for the orpsoc top level. It replaces the single fixed-delay bench reset with up to NUM_CH reset domains, such as CPU, memory, debug and peripherals. Domains are released one at a time, in index order, each after a programmable step delay or after that domain reports ready. An optional ready-timeout watchdog flags a domain that never comes up. The block sits between the board/bench reset source and the per-domain `*_rst_i` inputs.

## Interface
- NUM_CH, 4: number of reset domains (1..16).
- CNT_W, 16: counter width; must hold max(HOLD_CYCLES, STEP_CYCLES, ACK_TIMEOUT).
- HOLD_CYCLES, 5: cycles all domains stay in reset after wb_rst_n_i deasserts (≥1).
- STEP_CYCLES, 8: wait after releasing an unmasked domain (≥1).
- ACK_MASK, 0: bit k=1 means domain k waits for ch_ack_i[k] instead of STEP_CYCLES.
- ACK_TIMEOUT, 1024: ready-wait limit in cycles (watchdog build only).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  reset, synchronous, active-low.
- soft_rst_i  in  1  restart sequence (level, active-high).
- ch_ack_i  in  NUM_CH  per-domain ready (init_done style).
- ch_rst_o  out  NUM_CH  per-domain reset, active-high, registered.
- seq_done_o  out  1  all domains released.
- fault_o  out  1  ready timeout occurred (sticky).
- fault_ch_o  out  $clog2(NUM_CH) (min 1)  domain that timed out.

## Operation
- FSM states: HOLD, WAIT, RUN, FAULT. idx is the domain currently being processed. cnt is the cycle counter.
- Reset (wb_rst_n_i=0 at an edge):
  - state=HOLD, cnt=0, idx=0.
  - ch_rst_o = all ones; seq_done_o=0, fault_o=0, fault_ch_o=0.
- HOLD: cnt increments each cycle. When cnt==HOLD_CYCLES-1:
  - clear ch_rst_o[0], set cnt=0, go to WAIT.
- WAIT, unmasked idx: cnt increments. When cnt==STEP_CYCLES-1 the domain is complete.
- WAIT, masked idx: the domain is complete in the cycle ch_ack_i[idx] is sampled high. cnt still counts as the timeout timer.
- Domain complete, idx<NUM_CH-1: idx++, clear ch_rst_o[idx+1], cnt=0.
- Domain complete, idx==NUM_CH-1: go to RUN, seq_done_o=1.
- RUN: holds. ch_ack_i is ignored.
- Watchdog timeout (masked idx, cnt==ACK_TIMEOUT-1 with no ack):
  - go to FAULT; fault_o=1, fault_ch_o=idx.
  - Domains 0..idx stay released; domains idx+1.. stay in reset.
- FAULT: holds until soft_rst_i or wb_rst_n_i.
- soft_rst_i=1 in any state: next edge behaves as reset, except fault_o and fault_ch_o are kept. This lets software read the cause. While soft_rst_i is held high, the block stays in HOLD with cnt=0.
- Priorities: wb_rst_n_i > soft_rst_i > ack > timeout. Ack and timeout in the same cycle counts as a success.
- ch_ack_i of non-current or unmasked domains is ignored.

## Timing
- Edge numbering: edge 1 is the first edge with wb_rst_n_i=1 and soft_rst_i=0. "Edge n" means the output changes after that edge.
- ch_rst_o[0] falls at edge HOLD_CYCLES.
- All unmasked: ch_rst_o[k] falls at edge HOLD_CYCLES + k·STEP_CYCLES; seq_done_o rises at edge HOLD_CYCLES + NUM_CH·STEP_CYCLES.
- Masked domain: the next domain is released at the edge that samples the ack (1-cycle latency). An ack present on the release edge is sampled at the following edge.
- Timeout: fault_o rises ACK_TIMEOUT edges after that domain's release.
- Outputs only change on a rising wb_clk_i edge. There are no combinational paths from input to output.

## Configuration
- ORPSOC_RST_SEQ_WDOG_EN defined:
  - timeout logic and FAULT state are present.
  - ACK_TIMEOUT is enforced.
- Not defined:
  - masked domains wait indefinitely.
  - fault_o and fault_ch_o are tied to 0.
  - FAULT state is unreachable and removed.

## Structure
- orpsoc_rst_seq_pkg holds:
  - the state typedef (HOLD, WAIT, RUN, FAULT).
  - the idx-width helper function (max(1,$clog2(NUM_CH))).
- A single module with the counter inline. A sub-module is not warranted.

## Test plan
All scenarios use NUM_CH=4, HOLD=5, STEP=8.
- ACK_MASK=0 -> ch_rst_o bits fall at edges 5/13/21/29; seq_done_o=1 at edge 37; fault_o stays 0.
- ACK_MASK=4'b0010, ch_ack_i[1] driven high before edge 20 -> ch_rst_o[2] falls at edge 20; the rest follow by +8.
- Watchdog build, ACK_TIMEOUT=16, ch1 masked and never acks -> fault_o=1, fault_ch_o=1 at edge 29. ch_rst_o=4'b1100, held for 50 cycles.
- From FAULT, pulse soft_rst_i for 1 cycle -> ch_rst_o=4'b1111 next edge, fault_o still 1, sequence restarts with HOLD timing.
- wb_rst_n_i=0 at edge 17 (mid-WAIT) -> next edge: ch_rst_o=4'b1111, seq_done_o=0, fault_o=0; full sequence repeats.
- Ack and timeout in the same cycle on ch1 -> no fault; ch2 released that edge.

Source files
------------

// File: rtl/orpsoc_rst_seq_pkg.sv
// Shared types and helpers for the orpsoc reset sequencer.
package orpsoc_rst_seq_pkg;

  typedef enum logic [1:0] {
    StHold,
    StWait,
    StRun,
    StFault
  } seq_state_e;

  // Width of a domain index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/orpsoc_rst_seq.sv
// Releases NUM_CH reset domains in index order, each after a fixed step or its ready ack.
// Define ORPSOC_RST_SEQ_WDOG_EN to add the ready-timeout watchdog and FAULT state.
module orpsoc_rst_seq
  import orpsoc_rst_seq_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       CNT_W       = 16,
  parameter int unsigned       HOLD_CYCLES = 5,
  parameter int unsigned       STEP_CYCLES = 8,
  parameter logic [NUM_CH-1:0] ACK_MASK    = '0,
  parameter int unsigned       ACK_TIMEOUT = 1024,
  localparam int unsigned      IdxW        = idx_width(NUM_CH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              soft_rst_i,
  input  logic [NUM_CH-1:0] ch_ack_i,
  output logic [NUM_CH-1:0] ch_rst_o,
  output logic              seq_done_o,
  output logic              fault_o,
  output logic [IdxW-1:0]   fault_ch_o
);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d, idx_next;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic              done_q, done_d;
  logic              step_done;
  logic              ack_expired;

  assign idx_next    = idx_q + IdxW'(1);
  assign ack_expired = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ch_rst_d  = ch_rst_q;
    done_d    = done_q;
    step_done = 1'b0;

    if (soft_rst_i) begin
      state_d  = StHold;
      cnt_d    = '0;
      idx_d    = '0;
      ch_rst_d = '1;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        StHold: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            ch_rst_d[0] = 1'b0;
            cnt_d       = '0;
            state_d     = StWait;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        StWait: begin
          if (ACK_MASK[idx_q]) begin
            step_done = ch_ack_i[idx_q];
          end else begin
            step_done = (cnt_q == CNT_W'(STEP_CYCLES - 1));
          end

          // An ack arriving on the timeout cycle still wins.
          if (step_done) begin
            cnt_d = '0;
            if (idx_q == IdxW'(NUM_CH - 1)) begin
              state_d = StRun;
              done_d  = 1'b1;
            end else begin
              idx_d              = idx_next;
              ch_rst_d[idx_next] = 1'b0;
            end
          end else if (ACK_MASK[idx_q] && ack_expired) begin
`ifdef ORPSOC_RST_SEQ_WDOG_EN
            state_d = StFault;
`endif
            // Without the watchdog the timer parks here and the domain waits forever.
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= StHold;
      cnt_q    <= '0;
      idx_q    <= '0;
      ch_rst_q <= '1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ch_rst_q <= ch_rst_d;
      done_q   <= done_d;
    end
  end

  assign ch_rst_o   = ch_rst_q;
  assign seq_done_o = done_q;

`ifdef ORPSOC_RST_SEQ_WDOG_EN
  logic            fault_q;
  logic [IdxW-1:0] fault_ch_q;

  // Survives soft_rst_i so software can read the cause after restarting.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      fault_q    <= 1'b0;
      fault_ch_q <= '0;
    end else if (state_q == StWait && state_d == StFault) begin
      fault_q    <= 1'b1;
      fault_ch_q <= idx_q;
    end
  end

  assign fault_o    = fault_q;
  assign fault_ch_o = fault_ch_q;
`else
  assign fault_o    = 1'b0;
  assign fault_ch_o = '0;
`endif

endmodule

// File: tb/tb_orpsoc_rst_seq.sv
// Directed bench: dut_a has all domains unmasked, dut_b masks domain 1 with a 16-cycle timeout.
module tb_orpsoc_rst_seq;

`ifdef ORPSOC_RST_SEQ_WDOG_EN
  localparam logic WdogEn = 1'b1;
`else
  localparam logic WdogEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       soft_rst;
  logic [3:0] ack;

  logic [3:0] a_ch_rst, b_ch_rst;
  logic       a_done, b_done;
  logic       a_fault, b_fault;
  logic [1:0] a_fault_ch, b_fault_ch;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  orpsoc_rst_seq #(
    .NUM_CH     (4),
    .CNT_W      (16),
    .HOLD_CYCLES(5),
    .STEP_CYCLES(8),
    .ACK_MASK   (4'b0000),
    .ACK_TIMEOUT(16)
  ) dut_a (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .soft_rst_i(soft_rst),
    .ch_ack_i  (ack),
    .ch_rst_o  (a_ch_rst),
    .seq_done_o(a_done),
    .fault_o   (a_fault),
    .fault_ch_o(a_fault_ch)
  );

  orpsoc_rst_seq #(
    .NUM_CH     (4),
    .CNT_W      (16),
    .HOLD_CYCLES(5),
    .STEP_CYCLES(8),
    .ACK_MASK   (4'b0010),
    .ACK_TIMEOUT(16)
  ) dut_b (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .soft_rst_i(soft_rst),
    .ch_ack_i  (ack),
    .ch_rst_o  (b_ch_rst),
    .seq_done_o(b_done),
    .fault_o   (b_fault),
    .fault_ch_o(b_fault_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the given edge of the current sequence, then settle 1 time unit.
  task automatic adv_to(input int target);
    while (edge_n < target) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    soft_rst = 1'b0;
    ack      = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("por_a_rst", {4'b0, a_ch_rst}, 8'h0f);
    chk("por_a_done", {7'b0, a_done}, 8'h00);
    chk("por_a_fault", {7'b0, a_fault}, 8'h00);
    chk("por_b_rst", {4'b0, b_ch_rst}, 8'h0f);
    chk("por_b_fault_ch", {6'b0, b_fault_ch}, 8'h00);

    // Run 1: plain stepping on dut_a, domain 1 of dut_b never acks.
    rst_n  = 1'b1;
    edge_n = 0;
    adv_to(4);
    chk("r1_a_e4", {4'b0, a_ch_rst}, 8'h0f);
    adv_to(5);
    chk("r1_a_e5", {4'b0, a_ch_rst}, 8'h0e);
    chk("r1_b_e5", {4'b0, b_ch_rst}, 8'h0e);
    adv_to(12);
    chk("r1_a_e12", {4'b0, a_ch_rst}, 8'h0e);
    adv_to(13);
    chk("r1_a_e13", {4'b0, a_ch_rst}, 8'h0c);
    adv_to(21);
    chk("r1_a_e21", {4'b0, a_ch_rst}, 8'h08);
    adv_to(28);
    chk("r1_b_e28_fault", {7'b0, b_fault}, 8'h00);
    adv_to(29);
    chk("r1_a_e29", {4'b0, a_ch_rst}, 8'h00);
    chk("r1_b_e29_rst", {4'b0, b_ch_rst}, 8'h0c);
    chk("r1_b_e29_fault", {7'b0, b_fault}, {7'b0, WdogEn});
    chk("r1_b_e29_fault_ch", {6'b0, b_fault_ch}, {6'b0, WdogEn, 1'b0} >> 1);
    adv_to(36);
    chk("r1_a_e36_done", {7'b0, a_done}, 8'h00);
    adv_to(37);
    chk("r1_a_e37_done", {7'b0, a_done}, 8'h01);
    chk("r1_a_fault", {7'b0, a_fault}, 8'h00);
    adv_to(79);
    chk("r1_b_hold_rst", {4'b0, b_ch_rst}, 8'h0c);
    chk("r1_b_hold_fault", {7'b0, b_fault}, {7'b0, WdogEn});
    chk("r1_b_hold_done", {7'b0, b_done}, 8'h00);
    chk("r1_a_hold_done", {7'b0, a_done}, 8'h01);

    // One-cycle soft reset: outputs back in reset, fault kept.
    soft_rst = 1'b1;
    adv_to(80);
    chk("soft_a_rst", {4'b0, a_ch_rst}, 8'h0f);
    chk("soft_a_done", {7'b0, a_done}, 8'h00);
    chk("soft_b_rst", {4'b0, b_ch_rst}, 8'h0f);
    chk("soft_b_fault", {7'b0, b_fault}, {7'b0, WdogEn});
    chk("soft_b_fault_ch", {6'b0, b_fault_ch}, {7'b0, WdogEn});

    // Run 2: restart with HOLD timing, dut_b domain 1 acks before edge 20.
    soft_rst = 1'b0;
    edge_n   = 0;
    adv_to(4);
    chk("r2_b_e4", {4'b0, b_ch_rst}, 8'h0f);
    adv_to(5);
    chk("r2_a_e5", {4'b0, a_ch_rst}, 8'h0e);
    adv_to(19);
    chk("r2_b_e19", {4'b0, b_ch_rst}, 8'h0c);
    ack = 4'b0010;
    adv_to(20);
    chk("r2_b_e20", {4'b0, b_ch_rst}, 8'h08);
    chk("r2_a_e20", {4'b0, a_ch_rst}, 8'h0c);
    ack = 4'b0000;
    adv_to(21);
    chk("r2_a_e21", {4'b0, a_ch_rst}, 8'h08);
    adv_to(27);
    chk("r2_b_e27", {4'b0, b_ch_rst}, 8'h08);
    adv_to(28);
    chk("r2_b_e28", {4'b0, b_ch_rst}, 8'h00);
    adv_to(35);
    chk("r2_b_e35_done", {7'b0, b_done}, 8'h00);
    adv_to(36);
    chk("r2_b_e36_done", {7'b0, b_done}, 8'h01);
    adv_to(37);
    chk("r2_a_e37_done", {7'b0, a_done}, 8'h01);

    // Run 3: restart, then hard reset mid-WAIT at edge 17 clears fault too.
    soft_rst = 1'b1;
    adv_to(38);
    soft_rst = 1'b0;
    edge_n   = 0;
    adv_to(16);
    chk("r3_a_e16", {4'b0, a_ch_rst}, 8'h0c);
    chk("r3_b_e16_fault", {7'b0, b_fault}, {7'b0, WdogEn});
    rst_n = 1'b0;
    adv_to(17);
    chk("r3_a_e17_rst", {4'b0, a_ch_rst}, 8'h0f);
    chk("r3_a_e17_done", {7'b0, a_done}, 8'h00);
    chk("r3_b_e17_fault", {7'b0, b_fault}, 8'h00);
    chk("r3_b_e17_fault_ch", {6'b0, b_fault_ch}, 8'h00);

    // Run 4: full sequence again, dut_b ack lands on the timeout cycle.
    rst_n  = 1'b1;
    edge_n = 0;
    adv_to(5);
    chk("r4_a_e5", {4'b0, a_ch_rst}, 8'h0e);
    adv_to(13);
    chk("r4_a_e13", {4'b0, a_ch_rst}, 8'h0c);
    adv_to(28);
    chk("r4_b_e28", {4'b0, b_ch_rst}, 8'h0c);
    ack = 4'b0010;
    adv_to(29);
    chk("r4_b_e29_rst", {4'b0, b_ch_rst}, 8'h08);
    chk("r4_b_e29_fault", {7'b0, b_fault}, 8'h00);
    chk("r4_a_e29", {4'b0, a_ch_rst}, 8'h00);
    ack = 4'b0000;
    adv_to(37);
    chk("r4_a_e37_done", {7'b0, a_done}, 8'h01);
    chk("r4_b_e37", {4'b0, b_ch_rst}, 8'h00);
    adv_to(44);
    chk("r4_b_e44_done", {7'b0, b_done}, 8'h00);
    adv_to(45);
    chk("r4_b_e45_done", {7'b0, b_done}, 8'h01);
    adv_to(60);
    chk("r4_b_e60_fault", {7'b0, b_fault}, 8'h00);
    chk("r4_b_e60_done", {7'b0, b_done}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
